bcd2bin_seq: RTL

//  Sequential BCD-to-binary converter: the inverse of the bin2bcd double-dabble core.

---
 rtl/bcd2bin_seq_pkg.sv | 17 +
 rtl/bcd2bin_seq_if.sv | 17 +
 rtl/bcd2bin_seq_digit_adj.sv | 9 +
 rtl/bcd2bin_seq.sv | 94 +++++++++
 4 files changed

// File: rtl/bcd2bin_seq_pkg.sv
// Shared constants and state encoding for the sequential BCD-to-binary converter.
package bcd2bin_seq_pkg;
    localparam int         BCD_W   = 4;
    localparam logic [3:0] ADJ_TH  = 4'd8;
    localparam logic [3:0] ADJ_VAL = 4'd3;
    localparam logic [3:0] DIG_MAX = 4'd9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        ADJ   = 2'd2
    } state_t;

    function automatic logic digit_bad(input logic [BCD_W-1:0] d);
        return d > DIG_MAX;
    endfunction
endpackage

// File: rtl/bcd2bin_seq_if.sv
// Request/result bundle between a decimal-entry source and the converter.
interface bcd2bin_seq_if #(
    parameter int NDIG  = 5,
    parameter int NBITS = 16
);
    import bcd2bin_seq_pkg::*;

    logic                     start;
    logic [BCD_W*NDIG-1:0]    in_bcd;
    logic                     busy;
    logic                     done;
    logic [NBITS-1:0]         out_bin;
    logic                     err;

    modport master (output start, in_bcd, input busy, done, out_bin, err);
    modport slave  (input start, in_bcd, output busy, done, out_bin, err);
endinterface

// File: rtl/bcd2bin_seq_digit_adj.sv
// Reverse double-dabble correction for one BCD digit: subtract 3 when the digit is 8 or more.
module bcd2bin_seq_digit_adj
    import bcd2bin_seq_pkg::*;
(
    input  logic [BCD_W-1:0] d,
    output logic [BCD_W-1:0] q
);
    assign q = (d >= ADJ_TH) ? d - ADJ_VAL : d;
endmodule

// File: rtl/bcd2bin_seq.sv
// Sequential BCD-to-binary converter: NBITS rounds of shift-right then per-digit adjust.
module bcd2bin_seq
    import bcd2bin_seq_pkg::*;
#(
    parameter int NDIG  = 5,
    parameter int NBITS = 16
) (
    input  logic          clk,
    input  logic          rst,
    bcd2bin_seq_if.slave  bus
);
    localparam int DW = BCD_W * NDIG;
    localparam int W  = DW + NBITS;
    localparam int CW = $clog2(NBITS + 1);

    state_t           state;
    logic [W-1:0]     data;
    logic [CW-1:0]    cnt;
    logic             dig_err;
    logic             busy_r;
    logic             done_r;
    logic             err_r;
    logic [NBITS-1:0] out_r;

    logic [DW-1:0]    bcd_adj;
    logic             in_bad;
    logic             fin_err;

    // One adjuster per digit of the bcd half of the working register
    for (genvar g = 0; g < NDIG; g++) begin : g_adj
        bcd2bin_seq_digit_adj u_adj (
            .d (data[NBITS + BCD_W*g +: BCD_W]),
            .q (bcd_adj[BCD_W*g +: BCD_W])
        );
    end

    always_comb begin
        in_bad = 1'b0;
        for (int i = 0; i < NDIG; i++)
            if (digit_bad(bus.in_bcd[BCD_W*i +: BCD_W])) in_bad = 1'b1;
    end

    // Anything left in the bcd half after the last round means the value did not fit
    assign fin_err = dig_err | (|bcd_adj);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            data    <= '0;
            cnt     <= '0;
            dig_err <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
            out_r   <= '0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        data    <= {bus.in_bcd, {NBITS{1'b0}}};
                        cnt     <= '0;
                        busy_r  <= 1'b1;
                        dig_err <= in_bad;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    data  <= data >> 1;
                    cnt   <= cnt + CW'(1);
                    state <= ADJ;
                end
                ADJ: begin
                    data[W-1:NBITS] <= bcd_adj;
                    if (cnt == CW'(NBITS)) begin
                        err_r  <= fin_err;
                        out_r  <= fin_err ? '0 : data[NBITS-1:0];
                        done_r <= 1'b1;
                        busy_r <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        state <= SHIFT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.err     = err_r;
    assign bus.out_bin = out_r;
endmodule
